// File: rtl/matrix_multiply_sequencer.sv
// matrix_multiply_sequencer
//   Control end of the matrix_multiply datapath. Walks C = A x B for square
//   N x N matrices, presenting one ROM address pair per cycle (k innermost,
//   then j, then i), accumulates the returning two-product partial sums and
//   writes each finished C element to the result RAM in address order.
//
// Ports
//   clock                  : system clock, rising edge
//   reset                  : synchronous, active-high
//   start                  : one-cycle pulse, begins a multiply when idle
//   result_multiply_matrix : partial sum for the pair issued PIPE_LAT cycles ago
//   Q_A / Qnext_A          : ROM A addresses of A[i][k] / A[i][k+1]
//   address_a_ROMB / _b_   : ROM B addresses of B[k][j] / B[k+1][j]
//   done_counter           : every address pair has been issued
//   c_wr_en/addr/data      : result RAM write strobe, address i*N+j, dot product
//   busy                   : high while issuing and draining
//   done                   : one-cycle pulse after the final C write
module matrix_multiply_sequencer #(
    parameter int N        = 128,
    parameter int PIPE_LAT = 4,
    parameter int ADDR_W   = 2 * $clog2(N),
    parameter int ACC_W    = 17 + $clog2(N) - 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [16:0]       result_multiply_matrix,
    output logic [ADDR_W-1:0] Q_A,
    output logic [ADDR_W-1:0] Qnext_A,
    output logic [ADDR_W-1:0] address_a_ROMB,
    output logic [ADDR_W-1:0] address_b_ROMB,
    output logic              done_counter,
    output logic              c_wr_en,
    output logic [ADDR_W-1:0] c_wr_addr,
    output logic [ACC_W-1:0]  c_wr_data,
    output logic              busy,
    output logic              done
);
    localparam int LOG_N = $clog2(N);

    typedef logic [LOG_N-1:0] idx_t;

    localparam idx_t              IDX_LAST = idx_t'(N - 1);
    localparam idx_t              K_LAST   = idx_t'(N - 2);
    localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(N * N - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic valid;
        logic last;
        idx_t i;
        idx_t j;
    } tag_t;

    state_t           state, next_state;
    idx_t             i_cnt, j_cnt, k_cnt;
    idx_t             i_nxt, j_nxt, k_nxt;
    logic             load_first, issue_step, issue_final;
    tag_t             tag_pipe [PIPE_LAT];
    tag_t             tag_out;
    logic [ACC_W-1:0] acc, acc_sum;

    assign tag_out = tag_pipe[PIPE_LAT-1];
    assign acc_sum = acc + ACC_W'(result_multiply_matrix);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // The counters always hold the pair currently on the address outputs,
    // so ISSUE tests the final pair directly. DRAIN ends on the write of the
    // last C element, which is when the final valid tag has retired.
    always_comb begin
        next_state  = state;
        load_first  = 1'b0;
        issue_step  = 1'b0;
        issue_final = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ISSUE;
                    load_first = 1'b1;
                end
            end
            ISSUE: begin
                issue_step = 1'b1;
                if (i_cnt == IDX_LAST && j_cnt == IDX_LAST && k_cnt == K_LAST) begin
                    issue_final = 1'b1;
                    next_state  = DRAIN;
                end
            end
            DRAIN: begin
                if (c_wr_en && c_wr_addr == C_LAST) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        i_nxt = i_cnt;
        j_nxt = j_cnt;
        k_nxt = k_cnt + idx_t'(2);
        if (load_first) begin
            i_nxt = '0;
            j_nxt = '0;
            k_nxt = '0;
        end else if (k_cnt == K_LAST) begin
            k_nxt = '0;
            if (j_cnt == IDX_LAST) begin
                j_nxt = '0;
                i_nxt = i_cnt + idx_t'(1);
            end else begin
                j_nxt = j_cnt + idx_t'(1);
            end
        end
    end

    // Address registers hold after the final pair; k is always even, so the
    // odd partner address is k with bit 0 set.
    always_ff @(posedge clock) begin
        if (reset) begin
            i_cnt          <= '0;
            j_cnt          <= '0;
            k_cnt          <= '0;
            Q_A            <= '0;
            Qnext_A        <= '0;
            address_a_ROMB <= '0;
            address_b_ROMB <= '0;
        end else if (load_first || (issue_step && !issue_final)) begin
            i_cnt          <= i_nxt;
            j_cnt          <= j_nxt;
            k_cnt          <= k_nxt;
            Q_A            <= ADDR_W'({i_nxt, k_nxt});
            Qnext_A        <= ADDR_W'({i_nxt, k_nxt | idx_t'(1)});
            address_a_ROMB <= ADDR_W'({k_nxt, j_nxt});
            address_b_ROMB <= ADDR_W'({k_nxt | idx_t'(1), j_nxt});
        end
    end

    // Tag for the pair presented this cycle; it reaches the end of the pipe
    // in the cycle its partial sum is on result_multiply_matrix.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned p = 0; p < PIPE_LAT; p++) tag_pipe[p] <= '0;
        end else begin
            tag_pipe[0] <= issue_step ? tag_t'{1'b1, k_cnt == K_LAST, i_cnt, j_cnt} : '0;
            for (int unsigned p = 1; p < PIPE_LAT; p++) tag_pipe[p] <= tag_pipe[p-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            c_wr_en   <= 1'b0;
            c_wr_addr <= '0;
            c_wr_data <= '0;
        end else begin
            c_wr_en <= 1'b0;
            if (tag_out.valid) begin
                if (tag_out.last) begin
                    c_wr_en   <= 1'b1;
                    c_wr_addr <= ADDR_W'({tag_out.i, tag_out.j});
                    c_wr_data <= acc_sum;
                    acc       <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    // Status outputs are registered decodes of the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            done_counter <= 1'b0;
        end else begin
            busy         <= (next_state == ISSUE) || (next_state == DRAIN);
            done         <= (next_state == DONE);
            done_counter <= (next_state == DRAIN) || (next_state == DONE);
        end
    end

endmodule
